// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its write buffer.
package dmem_pkg;

  localparam logic [63:0] DMEM_BASE = 64'h0000_0000_8000_0000;
  localparam int IDX_W = 32;

  typedef logic [63:0] dword_t;
  typedef logic [7:0] wmask_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    idx_t idx;
    dword_t data;
    wmask_t mask;
  } wb_entry_t;

  // Overlay the enabled bytes of upd onto base.
  function automatic dword_t merge_bytes(dword_t base, dword_t upd, wmask_t mask);
    dword_t r;
    r = base;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) r[8*b +: 8] = upd[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-side request/response bundle of the data-memory responder.
interface dmem_if;
  import dmem_pkg::*;

  logic req_valid;
  logic req_write;
  dword_t req_addr;
  dword_t req_wdata;
  wmask_t req_wmask;
  logic req_ready;
  logic resp_valid;
  dword_t resp_rdata;
  logic resp_err;
  logic wb_empty;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask,
    input req_ready, resp_valid, resp_rdata, resp_err, wb_empty
  );

  modport slave (
    input req_valid, req_write, req_addr, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata, resp_err, wb_empty
  );

endinterface

// File: rtl/dmem_wbuf.sv
// In-order store buffer FIFO; exposes every slot plus a valid vector for hit
// detection and forwarding.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic enq,
  input wb_entry_t enq_entry,
  input logic deq,
  output logic [$clog2(DEPTH)-1:0] head,
  output logic [$clog2(DEPTH):0] count,
  output wb_entry_t head_entry,
  output wb_entry_t entries [DEPTH],
  output logic [DEPTH-1:0] valid
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] tail;

  always_ff @(posedge clk) begin
    if (enq) entries[tail] <= enq_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10: count <= count + 1'b1;
        2'b01: count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PW'(i) - head} < count);
    end
  end

  assign head_entry = entries[head];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: stores go through dmem_wbuf and drain into a single-port
// array when no request is accepted; loads answer one cycle later. Build option DMEM_FWD_EN.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter logic [63:0] BASE = DMEM_BASE,
  parameter int AW = 12,
  parameter int WB_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  dmem_if.slave bus
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  dword_t offset;
  idx_t req_idx;
  logic in_range;
  logic hit;
  logic full;
  logic accept;
  logic load_acc;
  logic store_enq;
  logic drain;
  logic [PW-1:0] head;
  logic [PW-1:0] slot;
  logic [CW-1:0] count;
  logic [AW-1:0] drain_idx;
  wb_entry_t head_entry;
  wb_entry_t enq_entry;
  wb_entry_t entries [WB_DEPTH];
  logic [WB_DEPTH-1:0] valid;
  dword_t mem [1<<AW];
  dword_t load_word;

  always_comb begin
    offset = bus.req_addr - BASE;
    in_range = (bus.req_addr >= BASE) && (offset < (64'd8 << AW));
    req_idx = idx_t'(offset[AW+2:3]);
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (valid[i] && (entries[i].idx == req_idx)) hit = 1'b1;
    end
    hit = hit & in_range;
  end

  assign full = (count == CW'(WB_DEPTH));

`ifdef DMEM_FWD_EN
  assign bus.req_ready = ~full;
`else
  assign bus.req_ready = ~full & (bus.req_write | ~hit);
`endif

  // The array port is free for draining only when no request is taken this cycle;
  // a full buffer refuses everything, which always frees the port for a drain.
  assign accept = bus.req_valid & bus.req_ready;
  assign load_acc = accept & ~bus.req_write;
  assign store_enq = accept & bus.req_write & in_range;
  assign drain = (count != '0) & ~accept;

  always_comb begin
    enq_entry.idx = req_idx;
    enq_entry.data = bus.req_wdata;
    enq_entry.mask = bus.req_wmask;
  end

  dmem_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
    .clk(clk),
    .rst(rst),
    .enq(store_enq),
    .enq_entry(enq_entry),
    .deq(drain),
    .head(head),
    .count(count),
    .head_entry(head_entry),
    .entries(entries),
    .valid(valid)
  );

  assign drain_idx = head_entry.idx[AW-1:0];

  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < 8; b++) begin
        if (head_entry.mask[b]) mem[drain_idx][8*b +: 8] <= head_entry.data[8*b +: 8];
      end
    end
  end

  // Overlay matching buffered stores oldest to youngest; without forwarding a load
  // is only accepted when nothing matches, so this reduces to the array word.
  always_comb begin
    load_word = mem[req_idx[AW-1:0]];
    slot = head;
    for (int k = 0; k < WB_DEPTH; k++) begin
      slot = head + PW'(k);
      if ((CW'(k) < count) && (entries[slot].idx == req_idx)) begin
        load_word = merge_bytes(load_word, entries[slot].data, entries[slot].mask);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err <= 1'b0;
    end else begin
      bus.resp_valid <= load_acc;
      if (load_acc) begin
        bus.resp_err <= ~in_range;
        bus.resp_rdata <= in_range ? load_word : '0;
      end
    end
  end

  assign bus.wb_empty = (count == '0);

endmodule
